// File: rtl/md_pad_pkg.sv
// Shared types and bit positions for the Mega Drive pad scanner.
package md_pad_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

   localparam int BTN_W      = 12;
   localparam int NUM_PHASES = 8;
   localparam int PHASE_W    = 3;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_A     = 4;
   localparam int BTN_B     = 5;
   localparam int BTN_C     = 6;
   localparam int BTN_START = 7;
   localparam int BTN_Z     = 8;
   localparam int BTN_Y     = 9;
   localparam int BTN_X     = 10;
   localparam int BTN_MODE  = 11;

   // Buttons every present pad reports; the upper four exist only on 6-button pads.
   localparam logic [BTN_W-1:0] BASE_MASK = 12'h0FF;

   localparam logic [PHASE_W-1:0] PH_DPAD  = 3'd0;
   localparam logic [PHASE_W-1:0] PH_START = 3'd1;
   localparam logic [PHASE_W-1:0] PH_ID    = 3'd5;
   localparam logic [PHASE_W-1:0] PH_EXT   = 3'd6;

   typedef struct packed {
      logic c_s;
      logic a_b;
      logic right;
      logic left;
      logic down;
      logic up;
   } pad_pins_t;

endpackage

// File: rtl/md_pad_scanner_lane.sv
// Per-pad shadow capture during a scan and commit to the published word.
module md_pad_scanner_lane
   import md_pad_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               sample,
   input  logic               commit,
   input  logic [PHASE_W-1:0] phase,
   input  pad_pins_t          pins,
   output logic [BTN_W-1:0]   btn,
   output logic               present,
   output logic               six
);

   logic [BTN_W-1:0] sh;
   logic             sh_present;
   logic             sh_six;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sh         <= '0;
         sh_present <= 1'b0;
         sh_six     <= 1'b0;
      end else if (sample) begin
         case (phase)
            PH_DPAD: begin
               sh[BTN_UP]    <= ~pins.up;
               sh[BTN_DOWN]  <= ~pins.down;
               sh[BTN_LEFT]  <= ~pins.left;
               sh[BTN_RIGHT] <= ~pins.right;
               sh[BTN_B]     <= ~pins.a_b;
               sh[BTN_C]     <= ~pins.c_s;
            end
            PH_START: begin
               sh[BTN_A]     <= ~pins.a_b;
               sh[BTN_START] <= ~pins.c_s;
               sh_present    <= ~pins.left & ~pins.right;
            end
            // A 6-button pad pulls all four direction pins low on its third sel-low.
            PH_ID: sh_six <= sh_present & ~(pins.up | pins.down | pins.left | pins.right);
            PH_EXT: begin
               if (sh_six) begin
                  sh[BTN_Z]    <= ~pins.up;
                  sh[BTN_Y]    <= ~pins.down;
                  sh[BTN_X]    <= ~pins.left;
                  sh[BTN_MODE] <= ~pins.right;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         btn     <= '0;
         present <= 1'b0;
         six     <= 1'b0;
      end else if (commit) begin
         present <= sh_present;
         six     <= sh_present & sh_six;
         if (!sh_present) btn <= '0;
         else if (sh_six) btn <= sh;
         else             btn <= sh & BASE_MASK;
      end
   end

endmodule

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for one asynchronous pad pin.
module sync_bit #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) ff <= {STAGES{RST_VAL}};
      else        ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/md_pad_scanner.sv
// Mega Drive joypad scanner: shared sel sequencer, per-pad synchronisers and decode lanes.
module md_pad_scanner
   import md_pad_pkg::*;
#(
   parameter int PADS        = 2,
   parameter int PHASE_CLKS  = 250,
   parameter int IDLE_CLKS   = 100000,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [PADS-1:0]       pad_up,
   input  logic [PADS-1:0]       pad_down,
   input  logic [PADS-1:0]       pad_left,
   input  logic [PADS-1:0]       pad_right,
   input  logic [PADS-1:0]       pad_a_b,
   input  logic [PADS-1:0]       pad_c_s,
   output logic [PADS-1:0]       pad_sel,
   output logic [PADS*BTN_W-1:0] buttons,
   output logic [PADS-1:0]       pad_present,
   output logic [PADS-1:0]       pad_six,
   output logic                  frame_valid
);

   localparam int MAX_CLKS = (PHASE_CLKS > IDLE_CLKS) ? PHASE_CLKS : IDLE_CLKS;
   localparam int CNT_W    = $clog2(MAX_CLKS);
   localparam logic [CNT_W-1:0]   PHASE_LAST = CNT_W'(PHASE_CLKS - 1);
   localparam logic [CNT_W-1:0]   IDLE_LAST  = CNT_W'(IDLE_CLKS - 1);
   localparam logic [PHASE_W-1:0] PH_LAST    = PHASE_W'(NUM_PHASES - 1);

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [PHASE_W-1:0] phase, phase_n;
   logic               sel_q, sel_n;
   logic               fv_q;
   logic               sample, commit;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         phase <= '0;
         sel_q <= 1'b1;
         fv_q  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         phase <= phase_n;
         sel_q <= sel_n;
         fv_q  <= commit;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      phase_n = phase;
      sample  = 1'b0;
      commit  = 1'b0;
      case (state)
         IDLE: begin
            // Count saturates at the end of idle until enable allows the next scan.
            if (cnt == IDLE_LAST) begin
               if (enable) begin
                  state_n = SCAN;
                  cnt_n   = '0;
                  phase_n = '0;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         SCAN: begin
            if (cnt == PHASE_LAST) begin
               sample = 1'b1;
               cnt_n  = '0;
               if (phase == PH_LAST) state_n = COMMIT;
               else                  phase_n = phase + 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         COMMIT: begin
            commit  = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
            phase_n = '0;
         end
         default: state_n = IDLE;
      endcase
      // sel is registered from the next state so it moves on the same edge as the phase.
      sel_n = (state_n == SCAN) ? ~phase_n[0] : 1'b1;
   end

   assign pad_sel     = {PADS{sel_q}};
   assign frame_valid = fv_q;

   for (genvar p = 0; p < PADS; p++) begin : g_pad
      logic [5:0] raw_bits, syn_bits;
      pad_pins_t  syn;

      assign raw_bits = {pad_c_s[p], pad_a_b[p], pad_right[p], pad_left[p], pad_down[p], pad_up[p]};

      for (genvar b = 0; b < 6; b++) begin : g_sync
         sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
            .clock (clock),
            .reset (reset),
            .d     (raw_bits[b]),
            .q     (syn_bits[b])
         );
      end

      assign syn = pad_pins_t'(syn_bits);

      md_pad_scanner_lane u_lane (
         .clock   (clock),
         .reset   (reset),
         .sample  (sample),
         .commit  (commit),
         .phase   (phase),
         .pins    (syn),
         .btn     (buttons[p*BTN_W +: BTN_W]),
         .present (pad_present[p]),
         .six     (pad_six[p])
      );
   end

endmodule

// File: tb/tb_md_pad_scanner.sv
// Scoreboard bench: behavioural Genesis pads (absent / 3-button / 6-button) on each port.
module tb_md_pad_scanner;
   import md_pad_pkg::*;

   localparam int PADS  = 2;
   localparam int PH    = 8;
   localparam int IDL   = 64;
   localparam int FRAME = IDL + NUM_PHASES * PH + 1;

   logic                  clock = 1'b0;
   logic                  reset = 1'b0;
   logic                  enable = 1'b0;
   logic [PADS-1:0]       pad_up, pad_down, pad_left, pad_right, pad_a_b, pad_c_s;
   logic [PADS-1:0]       pad_sel, pad_present, pad_six;
   logic [PADS*BTN_W-1:0] buttons;
   logic                  frame_valid;

   always #5 clock = ~clock;

   md_pad_scanner #(.PADS(PADS), .PHASE_CLKS(PH), .IDLE_CLKS(IDL), .SYNC_STAGES(2)) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .pad_up      (pad_up),
      .pad_down    (pad_down),
      .pad_left    (pad_left),
      .pad_right   (pad_right),
      .pad_a_b     (pad_a_b),
      .pad_c_s     (pad_c_s),
      .pad_sel     (pad_sel),
      .buttons     (buttons),
      .pad_present (pad_present),
      .pad_six     (pad_six),
      .frame_valid (frame_valid)
   );

   typedef struct {
      logic [PADS*BTN_W-1:0] btn;
      logic [PADS-1:0]       present;
      logic [PADS-1:0]       six;
      int                    gap;
   } exp_t;

   exp_t expq[$];
   int   checks = 0, failures = 0, frames_seen = 0, since = 0;
   int   ptype[PADS];          // 0 absent, 1 three-button, 2 six-button
   logic [11:0] held[PADS];    // active-high held buttons, word layout
   int   tcnt = 0, hcnt = 0;
   logic prev_sel = 1'b1;

   // Pad-side view: sel transitions since the pad last saw a long sel-high rest.
   always @(posedge clock) begin
      prev_sel <= pad_sel[0];
      if (pad_sel[0] != prev_sel) begin
         tcnt <= tcnt + 1;
         hcnt <= 0;
      end else begin
         hcnt <= hcnt + 1;
         if (pad_sel[0] && hcnt > 20) tcnt <= 0;
      end
   end

   function automatic logic [5:0] pad_pins(int ty, logic [11:0] h, logic sel, int t);
      if (ty == 0) return 6'b111111;
      if (sel) begin
         if (ty == 2 && t == 6)
            return ~{h[BTN_C], h[BTN_B], h[BTN_MODE], h[BTN_X], h[BTN_Y], h[BTN_Z]};
         return ~{h[BTN_C], h[BTN_B], h[BTN_RIGHT], h[BTN_LEFT], h[BTN_DOWN], h[BTN_UP]};
      end
      if (ty == 2 && t == 5) return {~h[BTN_START], ~h[BTN_A], 4'b0000};
      if (ty == 2 && t == 7) return {~h[BTN_START], ~h[BTN_A], 4'b1111};
      return {~h[BTN_START], ~h[BTN_A], 2'b00, ~h[BTN_DOWN], ~h[BTN_UP]};
   endfunction

   always_comb begin
      logic [5:0] pv;
      pv = '1;
      pad_up = '1; pad_down = '1; pad_left = '1; pad_right = '1; pad_a_b = '1; pad_c_s = '1;
      for (int p = 0; p < PADS; p++) begin
         pv = pad_pins(ptype[p], held[p], pad_sel[p], tcnt);
         pad_up[p]    = pv[0];
         pad_down[p]  = pv[1];
         pad_left[p]  = pv[2];
         pad_right[p] = pv[3];
         pad_a_b[p]   = pv[4];
         pad_c_s[p]   = pv[5];
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(logic [23:0] btn, logic [1:0] pr, logic [1:0] sx, int gap);
      exp_t e;
      e.btn = btn; e.present = pr; e.six = sx; e.gap = gap;
      expq.push_back(e);
   endtask

   task automatic wait_frames(int n);
      int target, t;
      target = frames_seen + n;
      t = 0;
      while (frames_seen < target && t < 2 * FRAME * n) begin
         @(posedge clock);
         t++;
      end
      checks++;
      if (frames_seen < target) begin
         failures++;
         $display("FAIL frame_timeout: saw %0d frames expected %0d", frames_seen, target);
      end
   endtask

   // Monitor: pops the scoreboard whenever a frame is published.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset) since = 0;
         else begin
            since++;
            if (frame_valid === 1'b1) begin
               if (expq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_frame: frame_valid with empty scoreboard");
               end else begin
                  e = expq.pop_front();
                  chk("buttons", 32'(buttons), 32'(e.btn));
                  chk("present", 32'(pad_present), 32'(e.present));
                  chk("six", 32'(pad_six), 32'(e.six));
                  if (e.gap > 0) chk("frame_gap", 32'(since), 32'(e.gap));
               end
               since = 0;
               frames_seen++;
            end
         end
      end
   end

   initial begin
      bit sel_ok;
      for (int p = 0; p < PADS; p++) begin ptype[p] = 0; held[p] = '0; end

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      chk("rst_sel", 32'(pad_sel), 32'h3);
      chk("rst_buttons", 32'(buttons), 32'h0);
      chk("rst_present", 32'(pad_present), 32'h0);
      chk("rst_six", 32'(pad_six), 32'h0);
      chk("rst_fv", 32'(frame_valid), 32'h0);

      // 1: no pads, free-running frames every IDL+8*PH+1 clocks
      enable = 1'b1;
      repeat (3) push(24'h0, 2'b00, 2'b00, FRAME);
      @(negedge clock);
      #2 reset = 1'b1;
      wait_frames(3);

      // 2: 3-button pad on port0, A+Start+Up -> bits 4,7,0
      ptype[0] = 1;
      held[0]  = 12'h091;
      repeat (2) push(24'h000091, 2'b01, 2'b00, FRAME);
      wait_frames(2);

      // 3: 6-button pad on port1, X+Mode+C -> bits 10,11,6
      ptype[1] = 2;
      held[1]  = 12'hC40;
      repeat (2) push(24'hC40091, 2'b11, 2'b10, FRAME);
      wait_frames(2);

      // 4: reset pulse during phase 3 (frame_valid edge + 64 idle + 3*8)
      repeat (89) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("midrst_sel", 32'(pad_sel), 32'h3);
      chk("midrst_buttons", 32'(buttons), 32'h0);
      chk("midrst_present", 32'(pad_present), 32'h0);
      chk("midrst_six", 32'(pad_six), 32'h0);
      chk("midrst_fv", 32'(frame_valid), 32'h0);
      push(24'hC40091, 2'b11, 2'b10, FRAME);
      @(negedge clock);
      #2 reset = 1'b1;
      wait_frames(1);

      // 5: drop enable in phase 4; that scan still commits, then sel rests high
      push(24'hC40091, 2'b11, 2'b10, FRAME);
      repeat (97) @(posedge clock);
      #1 enable = 1'b0;
      wait_frames(1);
      sel_ok = 1'b1;
      for (int i = 0; i < 3 * FRAME; i++) begin
         @(posedge clock);
         #1;
         if (pad_sel !== 2'b11) sel_ok = 1'b0;
      end
      chk("sel_idle_hold", 32'(sel_ok), 32'h1);

      // 6: unplug the 6-button pad, then resume scanning
      ptype[1] = 0;
      repeat (4) @(posedge clock);
      push(24'h000091, 2'b01, 2'b00, 0);
      push(24'h000091, 2'b01, 2'b00, FRAME);
      enable = 1'b1;
      wait_frames(2);

      repeat (10) @(posedge clock);
      chk("scoreboard_empty", 32'(expq.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
